cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter N_STAGES, default 5, number of sequential execution stages (2..16).
REQ-002 SHALL have parameter MEM_STAGE, default 3, stage index whose completion issues memory/IO commit.
REQ-003 SHALL have parameter WB_STAGE, default N_STAGES-1, stage index whose completion issues register commit.
REQ-004 SHALL have parameter BOOT_EN, default 1; 0 skips the loader phases.
REQ-005 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  freezes all state, counters and phase outputs.
- tx99_done, rx_size_done, rx_prog_done, txaa_done  in  1 each  loader phase completion.
- stage_done  in  N_STAGES  per-stage completion; multi-cycle units hold their bit low.
- halt_req  in  1  stop at the next instruction boundary.
- transmit_0x99, receive_program_data_size, receive_program_data, transmit_0xAA  out  1 each  loader phase active.
- run_active  out  1  high in RUN_EXEC, RUN_LATCH and HALT; drives stdin receive and stdout transmit.
- stage_active  out  N_STAGES  one-hot current stage in RUN_EXEC, else 0.
- latch_en  out  N_STAGES  one-cycle write enable of the register after the current stage.
- mem_commit  out  1  RAM write, stdin read and stdout write strobe.
- reg_commit  out  1  register file write strobe.
- pipeline_register_reset_n  out  1  low until RUN is first entered.
- halted  out  1  in HALT.
- retired  out  32  completed-instruction count.

Function
REQ-006 SHALL implement the states INIT, TX99, RXSIZE, RXPROG, TXAA, RUN_EXEC, RUN_LATCH and HALT, plus a stage index of $clog2(N_STAGES) bits.
REQ-007 SHALL, when stall is high, hold state, stage index and retired, and force mem_commit, reg_commit and latch_en to 0.
REQ-008 SHALL transition: INIT -> TX99 (BOOT_EN=1) or RUN_EXEC with stage 0 (BOOT_EN=0), unconditionally.
REQ-009 SHALL transition: TX99 -> RXSIZE on tx99_done; RXSIZE -> RXPROG on rx_size_done; RXPROG -> TXAA on rx_prog_done; TXAA -> RUN_EXEC with stage 0 on txaa_done; otherwise hold.
REQ-010 SHALL move RUN_EXEC -> RUN_LATCH in the cycle stage_done[idx] is high; SHALL ignore stage_done bits of other stages.
REQ-011 SHALL assert latch_en[idx] for exactly the one RUN_LATCH cycle, then return to RUN_EXEC with idx+1, or 0 when idx = N_STAGES-1.
REQ-012 SHALL, on the wrap to stage 0, increment retired modulo 2^32 and enter HALT instead of RUN_EXEC if halt_req is high in that cycle.
REQ-013 SHALL ignore halt_req at all other times; HALT is exited only by reset.
REQ-014 SHALL drive mem_commit combinationally high only when the state is RUN_EXEC, idx=MEM_STAGE, stage_done[idx]=1 and stall=0.
REQ-015 SHALL apply the same condition to reg_commit with WB_STAGE; each commit strobe is exactly one cycle per instruction.
REQ-016 SHALL, when MEM_STAGE=WB_STAGE, assert both commit strobes in the same cycle.
REQ-017 SHALL decode all loader, run_active, stage_active, halted and pipeline_register_reset_n outputs from registered state only (Moore).
REQ-018 SHALL give a minimum instruction period of 2*N_STAGES cycles with all stage_done bits high and no stall.

Reset
REQ-019 SHALL, on reset assertion at any time including mid-instruction or mid-load, immediately set state INIT, idx 0 and retired 0.
REQ-020 SHALL hold every output at 0 during and directly after reset, including pipeline_register_reset_n.
REQ-021 SHALL leave INIT on the first rising clk edge after reset deasserts, unless stall is high.

Structure
REQ-022 SHALL declare the state enum and default parameter constants in shared package cpu_seq_pkg.
REQ-023 SHALL be a single module with no sub-modules; the stage index, its one-hot decode and the retired counter are inline.

Verification
REQ-024 Boot: BOOT_EN=1; pulse tx99_done, rx_size_done, rx_prog_done, txaa_done one cycle each, 3 cycles apart -> each loader output is high only within its phase; run_active rises on the cycle after txaa_done.
REQ-025 Steady run: N_STAGES=5, stage_done all 1 -> latch_en cycles 00001..10000 with a 10-cycle period; mem_commit at stage 3, reg_commit at stage 4; retired=3 after 30 cycles of run.
REQ-026 Multi-cycle stage: hold stage_done[2]=0 for 7 cycles -> stage_active stays 00100 for 8 cycles; latch_en[2] pulses once; no extra commits.
REQ-027 Stall: stall for 4 cycles mid-RUN_EXEC of MEM_STAGE with stage_done high -> mem_commit is 0 throughout, fires once after stall drops; retired unchanged during stall.
REQ-028 Halt and reset: raise halt_req at stage 1 -> halted rises after the stage-4 latch with retired incremented once; then assert reset mid-RUN -> all outputs 0 asynchronously, retired=0.
REQ-029 Wrap: preload retired to 0xFFFFFFFF via a long run -> it wraps to 0 on the next instruction boundary.

Source files
------------

// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: shared state encoding and default parameters for the CPU sequencer
package cpu_seq_pkg;
    typedef enum logic [2:0] {
        S_INIT,
        S_TX99,
        S_RXSIZE,
        S_RXPROG,
        S_TXAA,
        S_RUN_EXEC,
        S_RUN_LATCH,
        S_HALT
    } seq_state_t;
    localparam int DEF_N_STAGES  = 5;
    localparam int DEF_MEM_STAGE = 3;
    localparam int DEF_BOOT_EN   = 1;
endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: boot loader phases followed by a multi-cycle stage sequencer with commit strobes
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int N_STAGES  = DEF_N_STAGES,
    parameter int MEM_STAGE = DEF_MEM_STAGE,
    parameter int WB_STAGE  = N_STAGES - 1,
    parameter int BOOT_EN   = DEF_BOOT_EN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                tx99_done,
    input  logic                rx_size_done,
    input  logic                rx_prog_done,
    input  logic                txaa_done,
    input  logic [N_STAGES-1:0] stage_done,
    input  logic                halt_req,
    output logic                transmit_0x99,
    output logic                receive_program_data_size,
    output logic                receive_program_data,
    output logic                transmit_0xAA,
    output logic                run_active,
    output logic [N_STAGES-1:0] stage_active,
    output logic [N_STAGES-1:0] latch_en,
    output logic                mem_commit,
    output logic                reg_commit,
    output logic                pipeline_register_reset_n,
    output logic                halted,
    output logic [31:0]         retired
);
    localparam int IW = $clog2(N_STAGES);
    localparam logic [IW-1:0] LAST_IDX = IW'(N_STAGES - 1);
    localparam logic [IW-1:0] MEM_IDX  = IW'(MEM_STAGE);
    localparam logic [IW-1:0] WB_IDX   = IW'(WB_STAGE);

    seq_state_t          r_state;
    logic [IW-1:0]       r_idx;
    logic [31:0]         r_retired;
    logic [N_STAGES-1:0] w_onehot;
    logic                w_done;
    logic                w_last;
    logic                w_exec_done;

    // The one-hot decode also masks stage_done so bits of other stages are ignored
    assign w_onehot    = N_STAGES'(1) << r_idx;
    assign w_done      = |(stage_done & w_onehot);
    assign w_last      = r_idx == LAST_IDX;
    assign w_exec_done = r_state == S_RUN_EXEC && w_done && !stall;

    // Sequencer state, stage index and retired count; stall freezes all of them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_INIT;
            r_idx     <= '0;
            r_retired <= '0;
        end else if (!stall) begin
            case (r_state)
                S_INIT: begin
                    r_state <= (BOOT_EN != 0) ? S_TX99 : S_RUN_EXEC;
                    r_idx   <= '0;
                end
                S_TX99:     if (tx99_done) r_state <= S_RXSIZE;
                S_RXSIZE:   if (rx_size_done) r_state <= S_RXPROG;
                S_RXPROG:   if (rx_prog_done) r_state <= S_TXAA;
                S_TXAA: if (txaa_done) begin
                    r_state <= S_RUN_EXEC;
                    r_idx   <= '0;
                end
                S_RUN_EXEC: if (w_done) r_state <= S_RUN_LATCH;
                S_RUN_LATCH: begin
                    r_idx   <= w_last ? '0 : r_idx + IW'(1);
                    r_state <= (w_last && halt_req) ? S_HALT : S_RUN_EXEC;
                    if (w_last) r_retired <= r_retired + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign transmit_0x99             = r_state == S_TX99;
    assign receive_program_data_size = r_state == S_RXSIZE;
    assign receive_program_data      = r_state == S_RXPROG;
    assign transmit_0xAA             = r_state == S_TXAA;
    assign run_active                = r_state == S_RUN_EXEC || r_state == S_RUN_LATCH || r_state == S_HALT;
    // RUN states are only reachable after RUN was entered and only reset leaves them
    assign pipeline_register_reset_n = run_active;
    assign halted                    = r_state == S_HALT;
    assign stage_active              = (r_state == S_RUN_EXEC) ? w_onehot : '0;
    assign latch_en                  = (r_state == S_RUN_LATCH && !stall) ? w_onehot : '0;
    assign mem_commit                = w_exec_done && r_idx == MEM_IDX;
    assign reg_commit                = w_exec_done && r_idx == WB_IDX;
    assign retired                   = r_retired;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: boot table, scoreboarded run sequences, stall/halt/reset corner cases
module tb_cpu_sequencer;
    localparam int NS = 5;

    logic          clk = 1'b0;
    logic          reset, stall, tx99_done, rx_size_done, rx_prog_done, txaa_done, halt_req;
    logic [NS-1:0] stage_done;
    logic          transmit_0x99, receive_program_data_size, receive_program_data, transmit_0xAA;
    logic          run_active, mem_commit, reg_commit, pipeline_register_reset_n, halted;
    logic [NS-1:0] stage_active, latch_en;
    logic [31:0]   retired;
    logic [50:0]   all_out;

    int errors = 0;
    int checks = 0;
    int m_st, m_idx;
    logic [31:0] m_ret;
    int n_mem, n_wb, n_latch2, n_sa2;

    typedef struct packed {
        logic          stall;
        logic [3:0]    dones;
        logic [3:0]    exp_ld;
        logic          exp_run;
        logic [NS-1:0] exp_sa;
    } boot_vec_t;
    boot_vec_t boot_tbl [14];

    typedef struct packed {
        logic          mem;
        logic          wb;
        logic [NS-1:0] latch;
    } comb_exp_t;
    comb_exp_t sb [$];

    cpu_sequencer #(.N_STAGES(NS), .MEM_STAGE(3), .WB_STAGE(4), .BOOT_EN(1)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .tx99_done(tx99_done), .rx_size_done(rx_size_done),
        .rx_prog_done(rx_prog_done), .txaa_done(txaa_done),
        .stage_done(stage_done), .halt_req(halt_req),
        .transmit_0x99(transmit_0x99), .receive_program_data_size(receive_program_data_size),
        .receive_program_data(receive_program_data), .transmit_0xAA(transmit_0xAA),
        .run_active(run_active), .stage_active(stage_active), .latch_en(latch_en),
        .mem_commit(mem_commit), .reg_commit(reg_commit),
        .pipeline_register_reset_n(pipeline_register_reset_n),
        .halted(halted), .retired(retired)
    );

    assign all_out = {transmit_0x99, receive_program_data_size, receive_program_data, transmit_0xAA,
                      run_active, stage_active, latch_en, mem_commit, reg_commit,
                      pipeline_register_reset_n, halted, retired};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_boot();
        for (int i = 0; i < 14; i++) begin
            stall = boot_tbl[i].stall;
            {tx99_done, rx_size_done, rx_prog_done, txaa_done} = boot_tbl[i].dones;
            @(posedge clk);
            #1;
            check($sformatf("boot_row%0d", i),
                  {transmit_0x99, receive_program_data_size, receive_program_data, transmit_0xAA,
                   run_active, pipeline_register_reset_n, stage_active},
                  {boot_tbl[i].exp_ld, boot_tbl[i].exp_run, boot_tbl[i].exp_run, boot_tbl[i].exp_sa});
        end
        {tx99_done, rx_size_done, rx_prog_done, txaa_done} = 4'b0;
        stall = 1'b0;
        m_st  = 0;
        m_idx = 0;
        m_ret = '0;
    endtask

    task automatic cycle(input logic st, input logic [NS-1:0] sd, input logic hr);
        comb_exp_t     e, got;
        logic [NS-1:0] exp_sa;
        stall      = st;
        stage_done = sd;
        halt_req   = hr;
        e.mem   = !st && m_st == 0 && sd[m_idx] && m_idx == 3;
        e.wb    = !st && m_st == 0 && sd[m_idx] && m_idx == 4;
        e.latch = (!st && m_st == 1) ? NS'(1) << m_idx : '0;
        sb.push_back(e);
        #3;
        got = sb.pop_front();
        check("commit_strobes", {mem_commit, reg_commit, latch_en}, got);
        n_mem    += int'(mem_commit);
        n_wb     += int'(reg_commit);
        n_latch2 += int'(latch_en[2]);
        if (!st) begin
            if (m_st == 0 && sd[m_idx]) m_st = 1;
            else if (m_st == 1) begin
                if (m_idx == NS - 1) begin
                    m_idx = 0;
                    m_ret = m_ret + 32'd1;
                    m_st  = hr ? 2 : 0;
                end else begin
                    m_idx++;
                    m_st = 0;
                end
            end
        end
        exp_sa = (m_st == 0) ? NS'(1) << m_idx : NS'(0);
        @(posedge clk);
        #1;
        check("moore_outputs",
              {transmit_0x99, receive_program_data_size, receive_program_data, transmit_0xAA,
               run_active, pipeline_register_reset_n, halted, stage_active, retired},
              {4'b0000, 1'b1, 1'b1, m_st == 2, exp_sa, m_ret});
        if (stage_active == 5'b00100) n_sa2++;
    endtask

    initial begin
        boot_tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 5'b00000};
        boot_tbl[1]  = '{1'b0, 4'b0000, 4'b1000, 1'b0, 5'b00000};
        boot_tbl[2]  = '{1'b0, 4'b0000, 4'b1000, 1'b0, 5'b00000};
        boot_tbl[3]  = '{1'b0, 4'b0000, 4'b1000, 1'b0, 5'b00000};
        boot_tbl[4]  = '{1'b0, 4'b1000, 4'b0100, 1'b0, 5'b00000};
        boot_tbl[5]  = '{1'b0, 4'b0001, 4'b0100, 1'b0, 5'b00000};
        boot_tbl[6]  = '{1'b0, 4'b0000, 4'b0100, 1'b0, 5'b00000};
        boot_tbl[7]  = '{1'b0, 4'b0100, 4'b0010, 1'b0, 5'b00000};
        boot_tbl[8]  = '{1'b0, 4'b0000, 4'b0010, 1'b0, 5'b00000};
        boot_tbl[9]  = '{1'b0, 4'b1000, 4'b0010, 1'b0, 5'b00000};
        boot_tbl[10] = '{1'b0, 4'b0010, 4'b0001, 1'b0, 5'b00000};
        boot_tbl[11] = '{1'b0, 4'b0000, 4'b0001, 1'b0, 5'b00000};
        boot_tbl[12] = '{1'b0, 4'b0000, 4'b0001, 1'b0, 5'b00000};
        boot_tbl[13] = '{1'b0, 4'b0001, 4'b0000, 1'b1, 5'b00001};

        reset = 1'b1;
        stall = 1'b0;
        {tx99_done, rx_size_done, rx_prog_done, txaa_done} = 4'b0;
        stage_done = '0;
        halt_req   = 1'b0;
        m_st = 0; m_idx = 0; m_ret = '0;
        n_mem = 0; n_wb = 0; n_latch2 = 0; n_sa2 = 0;

        #2 check("in_reset", all_out, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1 check("after_reset", all_out, 0);
        do_boot();

        repeat (30) cycle(1'b0, '1, 1'b0);
        check("steady_retired", retired, 3);
        check("steady_mem_commits", n_mem, 3);
        check("steady_reg_commits", n_wb, 3);

        n_mem = 0; n_wb = 0; n_latch2 = 0; n_sa2 = 0;
        repeat (4) cycle(1'b0, '1, 1'b0);
        repeat (7) cycle(1'b0, 5'b11011, 1'b0);
        repeat (6) cycle(1'b0, '1, 1'b0);
        check("mc_stage2_cycles", n_sa2, 8);
        check("mc_latch2_pulses", n_latch2, 1);
        check("mc_mem_commits", n_mem, 1);
        check("mc_reg_commits", n_wb, 1);
        check("mc_retired", retired, 4);

        n_mem = 0;
        repeat (6) cycle(1'b0, '1, 1'b0);
        repeat (4) cycle(1'b1, '1, 1'b0);
        check("stall_no_mem", n_mem, 0);
        check("stall_retired_held", retired, 4);
        repeat (4) cycle(1'b0, '1, 1'b0);
        check("stall_mem_once", n_mem, 1);
        check("stall_retired_after", retired, 5);

        repeat (2) cycle(1'b0, '1, 1'b0);
        repeat (8) cycle(1'b0, '1, 1'b1);
        check("halt_halted", halted, 1);
        check("halt_retired", retired, 6);
        repeat (3) cycle(1'b0, '1, 1'b0);
        check("halt_sticky", halted, 1);

        reset = 1'b1;
        #1 check("halt_reset", all_out, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        do_boot();
        repeat (13) cycle(1'b0, '1, 1'b0);
        check("rerun_retired", retired, 1);
        #2 reset = 1'b1;
        #1 check("async_reset_midrun", all_out, 0);
        repeat (2) @(posedge clk);
        #1 check("reset_held", all_out, 0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
